spi_cbus_master: RTL
====================

# spi_cbus_master

SPI-slave-to-cbus-master bridge. It receives 32-bit SPI frames from the board CPU and converts each frame into one cbus write or read cycle toward the register file. It drives cbus_addr, cbus_wdata, cbus_we and cbus_oe, and captures cbus_rdata after the fixed read latency. It sits between the FPGA SPI pins and every cbus responder in the design.

## Interface
Parameters:
- CBUS_ADDR_WIDTH, 12: cbus address width.
- CBUS_DATA_WIDTH, 8: cbus data width.
- CBUS_RD_LATENCY, 4: clocks from cbus_oe asserted until cbus_rdata is valid.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- spi_cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
- spi_sck  input  1  SPI clock, mode 0, asynchronous to clk.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_miso  output  1  SPI data out, MSB first.
- cbus_addr  output  CBUS_ADDR_WIDTH  registered cbus address.
- cbus_wdata  output  CBUS_DATA_WIDTH  registered write data.
- cbus_we  output  1  one-clock write strobe.
- cbus_oe  output  1  one-clock read strobe.
- cbus_rdata  input  CBUS_DATA_WIDTH  read data from the responders.
- abort_cnt  output  8  aborted-frame counter (see Configuration).

## Operation
- Frame format, 32 bits, MSB first:
  - bit31: R/W (1 = read).
  - bits30:28: reserved, ignored.
  - bits27:16: address.
  - bits15:8: turnaround, ignored.
  - bits7:0: write data (write frame) or read data on MISO (read frame).
- Synchronization:
  - spi_cs_n, spi_sck and spi_mosi each pass through a 2-flop synchronizer.
  - SCK edges are detected by comparing the 2nd and 3rd sync stages.
  - spi_mosi is sampled on the detected SCK rising edge.
- Bit counter, 6 bits:
  - Cleared while synchronized CS is high.
  - Increments on each SCK rise.
  - Saturates at 32; further bits are ignored until CS goes high.
- States:
  - IDLE: wait for CS low; go to SHIFT.
  - SHIFT: count bits.
    - On the 16th rise of a read frame, go to RD_ISSUE.
    - On the 32nd rise of a write frame, go to WR_ISSUE.
    - On CS high, go to IDLE.
  - RD_ISSUE: cbus_addr ← frame address; cbus_oe = 1 for one clock; go to RD_WAIT.
  - RD_WAIT: count CBUS_RD_LATENCY clocks from the oe cycle; latch cbus_rdata into the MISO shift register; go to SHIFT.
  - WR_ISSUE: cbus_addr and cbus_wdata ← frame fields; cbus_we = 1 for one clock; go to DONE.
  - DONE: wait for CS high; go to IDLE.
- SHIFT continues counting bits in parallel with RD_ISSUE and RD_WAIT.
- cbus_addr and cbus_wdata hold their value until the next access.
- cbus_we and cbus_oe are never high together.
- MISO:
  - Updated on the detected SCK fall after bit 24 through bit 31 (shifts out data bit 7 down to bit 0).
  - Driven 0 at all other times and for write frames.
- Aborted frame: CS rises before bit 32.
  - A write is never issued.
  - A read already issued completes on cbus; its data is discarded.
  - The state returns to IDLE once any RD_WAIT has finished.
- Reset mid-frame:
  - All state is cleared.
  - The block waits for CS high before accepting a new frame.

## Timing
- Reset values: spi_miso 0, cbus_addr 0, cbus_wdata 0, cbus_we 0, cbus_oe 0, abort_cnt 0.
- SCK period must be ≥ 8 clk periods; CS setup and hold must be ≥ 4 clk.
- Read strobe: cbus_oe asserts 1 clk after the 16th SCK rise is detected (about 4 clk after the pin edge).
- Read capture: cbus_rdata is sampled on the clk edge ending cycle T+CBUS_RD_LATENCY, where T is the oe cycle.
- The 8-bit turnaround gives ≥ 64 clk of margin before MISO bit 7 is needed.
- Write strobe: cbus_we asserts 1 clk after the 32nd SCK rise is detected.
- CS rising in the same clock that the 32nd rise is detected: the write is still issued and the frame is not counted as aborted.
- Back-to-back frames need CS high for ≥ 4 clk.

## Configuration
- Macro: SPI_CBUS_ABORT_CNT_EN.
- Defined:
  - abort_cnt increments by 1 on each frame aborted with 1 ≤ bits < 32.
  - It saturates at 8'hFF.
  - It clears only on rst.
- Not defined: abort_cnt is tied to 8'h00 and no counter logic is built.

## Test plan
- Write frame 0x0_002_00_A5 → one cbus_we pulse with cbus_addr=0x002, cbus_wdata=0xA5; cbus_oe stays 0.
- Read frame 0x8_001_00_00 with the responder model returning 0x10 at latency 4 → one cbus_oe pulse at address 0x001; MISO bits 7..0 = 0x10.
- Write 0x5A to 0x002, then read 0x002 from a model returning the inverted value → MISO = 0xA5.
- CS raised after 20 bits of a write frame → no cbus_we.
  - With SPI_CBUS_ABORT_CNT_EN: abort_cnt = 1.
  - Without it: abort_cnt = 0.
- rst asserted at bit 10 of a frame, released with CS still low → no cbus strobe; the next full frame after CS high executes normally.
- 40 SCK pulses in one write frame → exactly one cbus_we; bits 33 to 40 ignored.

Source files
------------

// File: rtl/spi_cbus_master.sv
// spi_cbus_master: SPI mode-0 slave that turns each 32-bit frame into one cbus access.
// Define SPI_CBUS_ABORT_CNT_EN to build the saturating aborted-frame counter.
module spi_cbus_master #(
  parameter int CBUS_ADDR_WIDTH = 12,
  parameter int CBUS_DATA_WIDTH = 8,
  parameter int CBUS_RD_LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_cs_n,
  input  logic                       spi_sck,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
  output logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
  output logic                       cbus_we,
  output logic                       cbus_oe,
  input  logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
  output logic [7:0]                 abort_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } state_t;

  localparam int WCW = $clog2(CBUS_RD_LATENCY + 1);

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     cs_q;
  logic [2:0]     sck_q;
  logic [1:0]     mosi_q;
  logic           cs_hi;
  logic           sck_rise;
  logic           sck_fall;
  logic           bit_ok;
  logic           armed;
  logic [5:0]     bitcnt;
  logic [30:0]    sr;
  logic [31:0]    sr_nxt;
  logic [WCW-1:0] wcnt;
  logic           wait_done;
  logic           ld_rd;
  logic           ld_wr;
  logic           rd_cap;
  logic           rd_frame;
  logic [7:0]     miso_sr;

  assign cs_hi     = cs_q[1];
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign bit_ok    = sck_rise & ~bitcnt[5];
  assign sr_nxt    = {sr, mosi_q[1]};
  assign wait_done = (wcnt == WCW'(CBUS_RD_LATENCY));

  // Bring the SPI pins into the clk domain; sck keeps a third stage for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= '0;
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[0], spi_cs_n};
      sck_q  <= {sck_q[1:0], spi_sck};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // After reset a frame is only accepted once CS has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (cs_hi) begin
      armed <= 1'b1;
    end
  end

  // Bit counter and frame shifter; bits past the 32nd are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      sr     <= '0;
    end else begin
      if (cs_hi) begin
        bitcnt <= '0;
      end else if (bit_ok) begin
        bitcnt <= bitcnt + 6'd1;
      end
      if (bit_ok) begin
        sr <= sr_nxt[30:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a 32nd write bit wins over a simultaneous CS rise.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!cs_hi && armed) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bit_ok && bitcnt == 6'd15 && sr_nxt[15]) begin
          state_nxt = RD_ISSUE;
        end else if (bit_ok && bitcnt == 6'd31 && !sr_nxt[31]) begin
          state_nxt = WR_ISSUE;
        end else if (cs_hi) begin
          state_nxt = IDLE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (wait_done) state_nxt = SHIFT;
      end
      WR_ISSUE: state_nxt = DONE;
      DONE: begin
        if (cs_hi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load strobes so that the cbus outputs are registered in the issue cycle.
  always_comb begin
    ld_rd  = (state == SHIFT) && (state_nxt == RD_ISSUE);
    ld_wr  = (state == SHIFT) && (state_nxt == WR_ISSUE);
    rd_cap = (state == RD_WAIT) && wait_done;
  end

  // Read latency counter: value k during cycle T+k after the oe cycle T.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == RD_ISSUE) begin
      wcnt <= WCW'(1);
    end else if (state == RD_WAIT) begin
      wcnt <= wcnt + WCW'(1);
    end
  end

  // cbus address/data hold between accesses; strobes last one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      cbus_addr  <= '0;
      cbus_wdata <= '0;
      cbus_we    <= 1'b0;
      cbus_oe    <= 1'b0;
    end else begin
      cbus_we <= ld_wr;
      cbus_oe <= ld_rd;
      if (ld_rd) begin
        cbus_addr <= CBUS_ADDR_WIDTH'(sr_nxt[11:0]);
      end
      if (ld_wr) begin
        cbus_addr  <= CBUS_ADDR_WIDTH'(sr_nxt[27:16]);
        cbus_wdata <= CBUS_DATA_WIDTH'(sr_nxt[7:0]);
      end
    end
  end

  // MISO shifter: read data goes out on the falls after bits 24..31.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_frame <= 1'b0;
      miso_sr  <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (rd_cap) begin
        miso_sr <= 8'(cbus_rdata);
      end
      if (cs_hi) begin
        rd_frame <= 1'b0;
        spi_miso <= 1'b0;
      end else begin
        if (ld_rd) begin
          rd_frame <= 1'b1;
        end
        if (sck_fall) begin
          if (rd_frame && bitcnt[5:3] == 3'b011) begin
            spi_miso <= miso_sr[7];
            miso_sr  <= {miso_sr[6:0], 1'b0};
          end else begin
            spi_miso <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SPI_CBUS_ABORT_CNT_EN
  logic cs_d;
  logic abort;

  assign abort = cs_q[1] & ~cs_d & (state != IDLE) &
                 (bitcnt != 6'd0) & ~bitcnt[5] &
                 ~(sck_rise && bitcnt == 6'd31);

  // Count frames cut short by CS, saturating at 8'hFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_d      <= 1'b0;
      abort_cnt <= '0;
    end else begin
      cs_d <= cs_q[1];
      if (abort && abort_cnt != 8'hFF) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end
`else
  assign abort_cnt = 8'h00;
`endif

endmodule
